// File: rtl/alu_regfile_ctrl.sv
// Operand/issue stage: 8x8 register file feeding an external 8-bit ALU.
// Optional REGFILE_R0_ZERO_EN makes r0 read as zero and ignore writes.
module alu_regfile_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_ld,
   input  logic [3:0] in_ctrl,
   input  logic [2:0] in_rd,
   input  logic [2:0] in_rs1,
   input  logic [2:0] in_rs2,
   input  logic [7:0] in_imm,
   output logic [3:0] alu_ctrl,
   output logic [7:0] alu_x,
   output logic [7:0] alu_y,
   input  logic       alu_carry,
   input  logic [7:0] alu_out,
   output logic       done_valid,
   output logic [7:0] done_data,
   output logic       done_carry,
   output logic       done_err,
   output logic       carry_flag,
   input  logic [2:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic {IDLE, EXEC} state_t;

   typedef struct packed {
      logic       ld;
      logic [3:0] ctrl;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [7:0] imm;
   } instr_t;

   state_t     state, nxt;
   instr_t     ir;
   logic [7:0] rf    [8];
   logic [7:0] rf_rd [8];
   logic       accept;
   logic       legal;
   logic       alu_op;
   logic       rf_we;
   logic [7:0] wr_data;

   always_comb begin
      for (int i = 0; i < 8; i++) rf_rd[i] = rf[i];
`ifdef REGFILE_R0_ZERO_EN
      rf_rd[0] = 8'h00;
`endif
   end

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign legal    = (ir.ctrl <= 4'd9);
   assign alu_op   = !ir.ld && legal;
   assign wr_data  = ir.ld ? ir.imm : alu_out;
   assign dbg_data = rf_rd[dbg_addr];

`ifdef REGFILE_R0_ZERO_EN
   assign rf_we = (state == EXEC) && (ir.ld || legal)
                  && (ir.rd != 3'd0);
`else
   assign rf_we = (state == EXEC) && (ir.ld || legal);
`endif

   always_comb begin
      nxt      = state;
      alu_ctrl = 4'h0;
      alu_x    = 8'h00;
      alu_y    = 8'h00;
      unique case (state)
         IDLE: begin
            if (accept) nxt = EXEC;
         end
         EXEC: begin
            nxt      = IDLE;
            alu_ctrl = ir.ctrl;
            alu_x    = rf_rd[ir.rs1];
            alu_y    = rf_rd[ir.rs2];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ir         <= '0;
         done_valid <= 1'b0;
         done_data  <= 8'h00;
         done_carry <= 1'b0;
         done_err   <= 1'b0;
         carry_flag <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      end else begin
         state      <= nxt;
         done_valid <= (state == EXEC);
         if (accept) begin
            ir.ld   <= in_ld;
            ir.ctrl <= in_ctrl;
            ir.rd   <= in_rd;
            ir.rs1  <= in_rs1;
            ir.rs2  <= in_rs2;
            ir.imm  <= in_imm;
         end
         if (state == EXEC) begin
            // Illegal ops report zero data and leave the carry flag alone
            done_data  <= (ir.ld || legal) ? wr_data : 8'h00;
            done_carry <= alu_op && alu_carry;
            done_err   <= !ir.ld && !legal;
            if (alu_op) carry_flag <= alu_carry;
         end
         if (rf_we) rf[ir.rd] <= wr_data;
      end
   end

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Bench for alu_regfile_ctrl: behavioural ALU, vector table, scoreboard.
// Define REGFILE_R0_ZERO_EN to check the zero-register build.
module tb_alu_regfile_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_ld;
   logic [3:0] in_ctrl;
   logic [2:0] in_rd;
   logic [2:0] in_rs1;
   logic [2:0] in_rs2;
   logic [7:0] in_imm;
   logic [3:0] alu_ctrl;
   logic [7:0] alu_x;
   logic [7:0] alu_y;
   logic       alu_carry;
   logic [7:0] alu_out;
   logic       done_valid;
   logic [7:0] done_data;
   logic       done_carry;
   logic       done_err;
   logic       carry_flag;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;

   alu_regfile_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ld(in_ld), .in_ctrl(in_ctrl), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
      .alu_carry(alu_carry), .alu_out(alu_out),
      .done_valid(done_valid), .done_data(done_data),
      .done_carry(done_carry), .done_err(done_err),
      .carry_flag(carry_flag),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream ALU; carry is carry-out for add and borrow for sub
   logic [8:0] s;
   always_comb begin
      s = 9'h000;
      case (alu_ctrl)
         4'd0: s = {1'b0, alu_x} + {1'b0, alu_y};
         4'd1: s = {1'b0, alu_x} - {1'b0, alu_y};
         4'd2: s = {1'b0, alu_x & alu_y};
         4'd3: s = {1'b0, alu_x | alu_y};
         4'd4: s = {1'b0, ~alu_x};
         4'd5: s = {1'b0, alu_x ^ alu_y};
         4'd6: s = {1'b0, ~(alu_x | alu_y)};
         4'd7: s = {1'b0, alu_y << alu_x[2:0]};
         4'd8: s = {1'b0, alu_y >> alu_x[2:0]};
         4'd9: s = {1'b0, alu_x[7], alu_x[7:1]};
         default: s = 9'h000;
      endcase
   end
   assign alu_out   = s[7:0];
   assign alu_carry = s[8];

   typedef struct packed {
      logic [7:0] d;
      logic       c;
      logic       e;
   } exp_t;

   typedef struct {
      logic       ld;
      logic [3:0] ctrl;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [7:0] imm;
      logic [7:0] data;
      logic       carry;
      logic       err;
      logic       flag;
      logic [7:0] dbg;
   } vec_t;

   exp_t sbq[$];
   vec_t tv[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_dbg(input string nm, input logic [2:0] a,
                          input logic [7:0] exp);
      dbg_addr = a;
      #1;
      chk(nm, dbg_data, exp);
   endtask

   always @(negedge clk) begin
      if (done_valid) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got data %h want none",
                     done_data);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("done_data", done_data, e.d);
            chk("done_carry", {7'h0, done_carry}, {7'h0, e.c});
            chk("done_err", {7'h0, done_err}, {7'h0, e.e});
         end
      end
   end

   task automatic issue(input logic ld, input logic [3:0] ctrl,
                        input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm,
                        input logic push, input logic [7:0] ed,
                        input logic ec, input logic ee,
                        input logic ovl);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got ready 0 want 1");
         return;
      end
      if (ovl) chk("overlap_done_valid", {7'h0, done_valid}, 8'h01);
      in_ld    = ld;
      in_ctrl  = ctrl;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_imm   = imm;
      in_valid = 1'b1;
      if (push) sbq.push_back('{d: ed, c: ec, e: ee});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_ld    = 1'b0;
      in_ctrl  = 4'h0;
      in_rd    = 3'd0;
      in_rs1   = 3'd0;
      in_rs2   = 3'd0;
      in_imm   = 8'h00;
      dbg_addr = 3'd0;

      //            ld ctrl rd rs1 rs2 imm    data  c  e  flag dbg
      tv.push_back('{1, 4'h0, 1, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, 8'hFF});
      tv.push_back('{1, 4'h0, 2, 0, 0, 8'h18, 8'h18, 0, 0, 0, 8'h18});
      tv.push_back('{0, 4'h0, 3, 1, 2, 8'h00, 8'h17, 1, 0, 1, 8'h17});
      tv.push_back('{1, 4'h0, 1, 0, 0, 8'h05, 8'h05, 0, 0, 1, 8'h05});
      tv.push_back('{1, 4'h0, 2, 0, 0, 8'h0A, 8'h0A, 0, 0, 1, 8'h0A});
      tv.push_back('{0, 4'h1, 4, 1, 2, 8'h00, 8'hFB, 1, 0, 1, 8'hFB});
      tv.push_back('{1, 4'h0, 6, 0, 0, 8'h66, 8'h66, 0, 0, 1, 8'h66});
      tv.push_back('{0, 4'hC, 6, 1, 2, 8'h00, 8'h00, 0, 1, 1, 8'h66});
      tv.push_back('{0, 4'h7, 5, 2, 1, 8'h00, 8'h14, 0, 0, 0, 8'h14});
      tv.push_back('{0, 4'h2, 7, 4, 5, 8'h00, 8'h10, 0, 0, 0, 8'h10});
      tv.push_back('{0, 4'h4, 7, 7, 7, 8'h00, 8'hEF, 0, 0, 0, 8'hEF});
      tv.push_back('{0, 4'h8, 3, 2, 4, 8'h00, 8'h3E, 0, 0, 0, 8'h3E});
      tv.push_back('{0, 4'h9, 3, 4, 4, 8'h00, 8'hFD, 0, 0, 0, 8'hFD});
      tv.push_back('{0, 4'h6, 3, 1, 2, 8'h00, 8'hF0, 0, 0, 0, 8'hF0});
      tv.push_back('{0, 4'h3, 3, 1, 2, 8'h00, 8'h0F, 0, 0, 0, 8'h0F});
      tv.push_back('{0, 4'hF, 3, 1, 2, 8'h00, 8'h00, 0, 1, 0, 8'h0F});

      repeat (2) @(negedge clk);
      chk("rst_in_ready", {7'h0, in_ready}, 8'h00);
      chk("rst_done_valid", {7'h0, done_valid}, 8'h00);
      chk("rst_carry_flag", {7'h0, carry_flag}, 8'h00);
      chk("rst_done_data", done_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {7'h0, in_ready}, 8'h01);
      for (int i = 0; i < 8; i++)
         chk_dbg("rst_rf", 3'(i), 8'h00);

      foreach (tv[i]) begin
         issue(tv[i].ld, tv[i].ctrl, tv[i].rd, tv[i].rs1, tv[i].rs2,
               tv[i].imm, 1'b1, tv[i].data, tv[i].carry, tv[i].err,
               1'b0);
         @(negedge clk);
         chk("exec_in_ready", {7'h0, in_ready}, 8'h00);
         @(negedge clk);
         chk("carry_flag", {7'h0, carry_flag}, {7'h0, tv[i].flag});
         chk_dbg("rf_after", tv[i].rd, tv[i].dbg);
      end

      // Back-to-back dependent xor, accepted while done_valid is high
      issue(1, 4'h0, 1, 0, 0, 8'h0A, 1, 8'h0A, 0, 0, 0);
      issue(1, 4'h0, 2, 0, 0, 8'h05, 1, 8'h05, 0, 0, 1);
      issue(0, 4'h5, 1, 1, 2, 8'h00, 1, 8'h0F, 0, 0, 1);
      issue(0, 4'h5, 1, 1, 2, 8'h00, 1, 8'h0A, 0, 0, 1);
      repeat (2) @(negedge clk);
      chk_dbg("b2b_r1", 3'd1, 8'h0A);

      // Reset during EXEC drops the load
      issue(1, 4'h0, 7, 0, 0, 8'h77, 0, 8'h00, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {7'h0, in_ready}, 8'h01);
      chk("post_rst_done", {7'h0, done_valid}, 8'h00);
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_done", {7'h0, done_valid}, 8'h00);
      end
      chk_dbg("post_rst_r7", 3'd7, 8'h00);
      chk_dbg("post_rst_r1", 3'd1, 8'h00);

      issue(1, 4'h0, 0, 0, 0, 8'h55, 1, 8'h55, 0, 0, 0);
      repeat (2) @(negedge clk);
`ifdef REGFILE_R0_ZERO_EN
      chk_dbg("r0_read", 3'd0, 8'h00);
      issue(0, 4'h0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk_dbg("r0_add", 3'd1, 8'h00);
`else
      chk_dbg("r0_read", 3'd0, 8'h55);
      issue(0, 4'h0, 1, 0, 0, 8'h00, 1, 8'hAA, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk_dbg("r0_add", 3'd1, 8'hAA);
`endif

      for (int n = 0; n < 10 && sbq.size() > 0; n++) @(negedge clk);
      if (sbq.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sbq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
